// File: rtl/oflow_sim_pkg.sv
// Shared types, term indices, RGB channel slices and L1 helpers for the
// similarity metric MAC.
package oflow_sim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IOU_WAIT,
        ACC,
        DONE
    } sim_state_t;

    localparam int TERM_IOU    = 0;
    localparam int TERM_W      = 1;
    localparam int TERM_H      = 2;
    localparam int TERM_COLOR0 = 3;

    // The history term follows the colour terms, so its index depends on NUM_COLORS.
    function automatic int term_hist(input int num_colors);
        return TERM_COLOR0 + num_colors;
    endfunction

    localparam int CH_LEN = 8;
    localparam int R_LSB  = 0;
    localparam int G_LSB  = 8;
    localparam int B_LSB  = 16;

    function automatic logic [15:0] l1_dist(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [9:0] l1_rgb(input logic [23:0] a, input logic [23:0] b);
        return 10'(l1_dist(16'(a[R_LSB +: CH_LEN]), 16'(b[R_LSB +: CH_LEN])))
             + 10'(l1_dist(16'(a[G_LSB +: CH_LEN]), 16'(b[G_LSB +: CH_LEN])))
             + 10'(l1_dist(16'(a[B_LSB +: CH_LEN]), 16'(b[B_LSB +: CH_LEN])));
    endfunction

endpackage

// File: rtl/oflow_calc_iou.sv
// Two-stage IoU of two {X_TL,Y_TL,X_BR,Y_BR} boxes; result is q0.IOU_LEN,
// saturated to all-ones for full overlap and zero for an empty union.
module oflow_calc_iou #(
    parameter int IOU_LEN = 22
) (
    input  logic               clk,
    input  logic               reset_N,
    input  logic               start,
    input  logic [63:0]        pos_cur,
    input  logic [63:0]        pos_prev,
    output logic               valid_iou,
    output logic [IOU_LEN-1:0] iou
);

    function automatic logic [15:0] span(input logic [15:0] lo, input logic [15:0] hi);
        return (hi > lo) ? hi - lo : 16'd0;
    endfunction

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [15:0]           ix, iy;
    logic [31:0]           area_cur, area_prev, inter_n, inter;
    logic [32:0]           uni;
    logic                  stage1;
    logic [IOU_LEN+31:0]   quot;

    assign ix = span(max16(pos_cur[63:48], pos_prev[63:48]), min16(pos_cur[31:16], pos_prev[31:16]));
    assign iy = span(max16(pos_cur[47:32], pos_prev[47:32]), min16(pos_cur[15:0], pos_prev[15:0]));
    assign area_cur  = 32'(span(pos_cur[63:48], pos_cur[31:16])) * 32'(span(pos_cur[47:32], pos_cur[15:0]));
    assign area_prev = 32'(span(pos_prev[63:48], pos_prev[31:16])) * 32'(span(pos_prev[47:32], pos_prev[15:0]));
    assign inter_n   = 32'(ix) * 32'(iy);
    assign quot      = {inter, {IOU_LEN{1'b0}}} / (IOU_LEN + 32)'(uni);

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            stage1    <= 1'b0;
            inter     <= '0;
            uni       <= '0;
            valid_iou <= 1'b0;
            iou       <= '0;
        end else begin
            stage1    <= start;
            valid_iou <= stage1;
            if (start) begin
                inter <= inter_n;
                uni   <= 33'(area_cur) + 33'(area_prev) - 33'(inter_n);
            end
            // A quotient of 1.0 or more only happens at full overlap.
            if (stage1)
                iou <= (uni == '0) ? '0 :
                       (|quot[IOU_LEN+31:IOU_LEN]) ? '1 : quot[IOU_LEN-1:0];
        end
    end

endmodule

// File: rtl/oflow_sim_metric_mac_term_sel.sv
// Combinational term selector: cnt picks the padded metric and its weight.
module oflow_sim_term_sel
    import oflow_sim_pkg::*;
#(
    parameter int NUM_COLORS = 2,
    parameter int WH_LEN     = 8,
    parameter int IOU_LEN    = 22,
    parameter int HIST_LEN   = 3,
    parameter int WEIGHT_LEN = 5,
    parameter int FRAC_BITS  = 10,
    parameter int CNT_LEN    = 5
) (
    input  logic [CNT_LEN-1:0]                  cnt,
    input  logic [IOU_LEN-1:0]                  iou,
    input  logic [WH_LEN-1:0]                   w_cur,
    input  logic [WH_LEN-1:0]                   w_prev,
    input  logic [WH_LEN-1:0]                   h_cur,
    input  logic [WH_LEN-1:0]                   h_prev,
    input  logic [NUM_COLORS*24-1:0]            colors_cur,
    input  logic [NUM_COLORS*24-1:0]            colors_prev,
    input  logic [HIST_LEN-1:0]                 dhist,
    input  logic [(4+NUM_COLORS)*WEIGHT_LEN-1:0] weights,
    output logic [24+FRAC_BITS-1:0]             metric,
    output logic [WEIGHT_LEN-1:0]               weight
);

    localparam int NUM_TERMS = 4 + NUM_COLORS;
    localparam int MET_LEN   = 24 + FRAC_BITS;
    localparam int TERM_HIST = term_hist(NUM_COLORS);

    logic [23:0] raw;

    // NOTE: every output gets a default at the top so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        raw    = '0;
        weight = '0;
        for (int t = 0; t < NUM_TERMS; t++)
            if (cnt == CNT_LEN'(t)) weight = weights[t*WEIGHT_LEN +: WEIGHT_LEN];
        if (cnt == CNT_LEN'(TERM_W))
            raw = 24'(l1_dist(16'(w_cur), 16'(w_prev)));
        else if (cnt == CNT_LEN'(TERM_H))
            raw = 24'(l1_dist(16'(h_cur), 16'(h_prev)));
        else if (cnt == CNT_LEN'(TERM_HIST))
            raw = 24'(1) << dhist;
        for (int c = 0; c < NUM_COLORS; c++)
            if (cnt == CNT_LEN'(TERM_COLOR0 + c))
                raw = 24'(l1_rgb(colors_cur[c*24 +: 24], colors_prev[c*24 +: 24]));
        // IoU is already fractional, so only its top bits are taken, unpadded.
        metric = (cnt == CNT_LEN'(TERM_IOU)) ? MET_LEN'(iou >> (IOU_LEN - FRAC_BITS))
                                             : {raw, {FRAC_BITS{1'b0}}};
    end

endmodule

// File: rtl/oflow_sim_metric_mac.sv
// Similarity scorer: IoU + weighted L1 terms accumulated by one sequential MAC.
// Optional per-frame minimum tracking is enabled by OFLOW_SIM_MIN_TRACK_EN.
module oflow_sim_metric_mac
    import oflow_sim_pkg::*;
#(
    parameter int NUM_COLORS    = 2,
    parameter int WH_LEN        = 8,
    parameter int IOU_LEN       = 22,
    parameter int HIST_LEN      = 3,
    parameter int WEIGHT_LEN    = 5,
    parameter int FRAC_BITS     = 10,
    parameter int SCORE_LEN     = 32,
    parameter int SCORE_FRAC    = 6,
    parameter int ID_LEN        = 12,
    parameter int PREFETCH_LEAD = 2,
    parameter int IOU_TIMEOUT   = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_N,
`ifdef OFLOW_SIM_MIN_TRACK_EN
    input  logic                                 frame_start,
    output logic [SCORE_LEN-1:0]                 min_score,
    output logic [ID_LEN-1:0]                    min_id,
`endif
    input  logic                                 start,
    input  logic [63:0]                          pos_cur,
    input  logic [WH_LEN-1:0]                    w_cur,
    input  logic [WH_LEN-1:0]                    h_cur,
    input  logic [NUM_COLORS*24-1:0]             colors_cur,
    input  logic [63:0]                          pos_prev,
    input  logic [WH_LEN-1:0]                    w_prev,
    input  logic [WH_LEN-1:0]                    h_prev,
    input  logic [NUM_COLORS*24-1:0]             colors_prev,
    input  logic [HIST_LEN-1:0]                  dhist_prev,
    input  logic [ID_LEN-1:0]                    id_prev,
    input  logic [(4+NUM_COLORS)*WEIGHT_LEN-1:0] weights,
    output logic                                 busy,
    output logic                                 prefetch,
    output logic                                 valid,
    output logic [SCORE_LEN-1:0]                 score,
    output logic [ID_LEN-1:0]                    id,
    output logic                                 iou_timeout
);

    localparam int NUM_TERMS = 4 + NUM_COLORS;
    localparam int ACC_LEN   = WEIGHT_LEN + FRAC_BITS + 24 + $clog2(NUM_TERMS);
    localparam int MET_LEN   = 24 + FRAC_BITS;
    localparam int PROD_LEN  = WEIGHT_LEN + MET_LEN;
    localparam int CNT_MAX   = (NUM_TERMS > IOU_TIMEOUT) ? NUM_TERMS : IOU_TIMEOUT;
    localparam int CNT_LEN   = $clog2(CNT_MAX + 1);
    localparam int WIN_LSB   = FRAC_BITS - SCORE_FRAC;

    sim_state_t                           state;
    logic [CNT_LEN-1:0]                   cnt;
    logic [ACC_LEN-1:0]                   acc, acc_next;
    logic [ACC_LEN+SCORE_LEN-1:0]         acc_ext;
    logic [SCORE_LEN-1:0]                 score_sat;
    logic [PROD_LEN-1:0]                  prod;
    logic [MET_LEN-1:0]                   metric;
    logic [WEIGHT_LEN-1:0]                weight;
    logic                                 iou_start, valid_iou;
    logic [IOU_LEN-1:0]                   iou, iou_q;
    logic [63:0]                          pos_cur_q, pos_prev_q;
    logic [WH_LEN-1:0]                    w_cur_q, w_prev_q, h_cur_q, h_prev_q;
    logic [NUM_COLORS*24-1:0]             colors_cur_q, colors_prev_q;
    logic [HIST_LEN-1:0]                  dhist_q;
    logic [ID_LEN-1:0]                    id_q;
    logic [(4+NUM_COLORS)*WEIGHT_LEN-1:0] weights_q;

    oflow_calc_iou #(.IOU_LEN(IOU_LEN)) u_iou (
        .clk(clk), .reset_N(reset_N), .start(iou_start),
        .pos_cur(pos_cur_q), .pos_prev(pos_prev_q),
        .valid_iou(valid_iou), .iou(iou)
    );

    oflow_sim_term_sel #(
        .NUM_COLORS(NUM_COLORS), .WH_LEN(WH_LEN), .IOU_LEN(IOU_LEN), .HIST_LEN(HIST_LEN),
        .WEIGHT_LEN(WEIGHT_LEN), .FRAC_BITS(FRAC_BITS), .CNT_LEN(CNT_LEN)
    ) u_sel (
        .cnt(cnt), .iou(iou_q), .w_cur(w_cur_q), .w_prev(w_prev_q), .h_cur(h_cur_q),
        .h_prev(h_prev_q), .colors_cur(colors_cur_q), .colors_prev(colors_prev_q),
        .dhist(dhist_q), .weights(weights_q), .metric(metric), .weight(weight)
    );

    assign prod      = PROD_LEN'(weight) * PROD_LEN'(metric);
    assign acc_next  = acc + ACC_LEN'(prod);
    assign acc_ext   = (ACC_LEN + SCORE_LEN)'(acc_next);
    // Anything left above the score window means the score cannot be represented.
    assign score_sat = (|(acc_ext >> (WIN_LSB + SCORE_LEN))) ? '1 : acc_ext[WIN_LSB +: SCORE_LEN];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state         <= IDLE;
            cnt           <= '0;
            acc           <= '0;
            prefetch      <= 1'b0;
            valid         <= 1'b0;
            score         <= '0;
            id            <= '0;
            iou_timeout   <= 1'b0;
            iou_start     <= 1'b0;
            iou_q         <= '0;
            pos_cur_q     <= '0;
            pos_prev_q    <= '0;
            w_cur_q       <= '0;
            w_prev_q      <= '0;
            h_cur_q       <= '0;
            h_prev_q      <= '0;
            colors_cur_q  <= '0;
            colors_prev_q <= '0;
            dhist_q       <= '0;
            id_q          <= '0;
            weights_q     <= '0;
        end else begin
            prefetch  <= 1'b0;
            valid     <= 1'b0;
            iou_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pos_cur_q     <= pos_cur;
                    pos_prev_q    <= pos_prev;
                    w_cur_q       <= w_cur;
                    w_prev_q      <= w_prev;
                    h_cur_q       <= h_cur;
                    h_prev_q      <= h_prev;
                    colors_cur_q  <= colors_cur;
                    colors_prev_q <= colors_prev;
                    dhist_q       <= dhist_prev;
                    id_q          <= id_prev;
                    weights_q     <= weights;
                    iou_start     <= 1'b1;
                    iou_timeout   <= 1'b0;
                    acc           <= '0;
                    cnt           <= '0;
                    state         <= IOU_WAIT;
                end
                IOU_WAIT: begin
                    if (valid_iou) begin
                        iou_q    <= iou;
                        cnt      <= '0;
                        prefetch <= (PREFETCH_LEAD == NUM_TERMS);
                        state    <= ACC;
                    end else if (cnt == CNT_LEN'(IOU_TIMEOUT - 1)) begin
                        iou_timeout <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    if (cnt == CNT_LEN'(NUM_TERMS - 1)) begin
                        valid <= 1'b1;
                        score <= score_sat;
                        id    <= id_q;
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        prefetch <= (cnt == CNT_LEN'(NUM_TERMS - PREFETCH_LEAD - 1));
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OFLOW_SIM_MIN_TRACK_EN
    logic [SCORE_LEN-1:0] min_base;
    logic [ID_LEN-1:0]    min_id_base;

    // A frame restart takes effect before a coincident compare.
    assign min_base    = frame_start ? '1 : min_score;
    assign min_id_base = frame_start ? '0 : min_id;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            min_score <= '1;
            min_id    <= '0;
        end else if (valid && (score < min_base)) begin
            min_score <= score;
            min_id    <= id;
        end else begin
            min_score <= min_base;
            min_id    <= min_id_base;
        end
    end
`endif

endmodule
